key_reader: RTL and testbench
=============================

KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable cycles (20 ms at 50 MHz) required to accept a level change; legal range is 2 or more.
REQ-002 Parameter LONG_CYCLES, default 50000000, is the number of held cycles (1 s) before a long-press indication; it SHALL be greater than DEBOUNCE_CYCLES.
REQ-003 CLOCK_50  input  1  single 50 MHz clock; all state SHALL change on its rising edge only.
REQ-004 RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 KEY  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-006 key_state  output  4  debounced level per key, 1 = pressed.
REQ-007 press_pulse  output  4  one-cycle strobe per key on an accepted press.
REQ-008 release_pulse  output  4  one-cycle strobe per key on an accepted release.
REQ-009 long_pulse  output  4  one-cycle strobe per key when a press has been held for LONG_CYCLES.

Function
REQ-010 Each of the 4 keys SHALL be processed by an identical, independent channel; no channel SHALL affect another.
REQ-011 Each KEY bit SHALL pass through a 2-flop synchronizer, and the second flop output is the "sampled" value, inverted so that 1 = pressed.
REQ-012 Each channel SHALL contain a debounce counter and a hold counter, each sized to ceil(log2(parameter)) bits, with no wrap-around; counters saturate or clear as stated below.
REQ-013 Each channel SHALL implement a 5-state FSM: IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_REL.
REQ-014 IDLE: when sampled = 1, the FSM SHALL go to DEB_PRESS with the debounce counter cleared; otherwise it stays in IDLE.
REQ-015 DEB_PRESS: sampled = 0 returns the FSM to IDLE with the counter cleared (bounce rejected); otherwise the counter increments, and when it reaches DEBOUNCE_CYCLES-1 the FSM goes to HELD, clears the hold counter, and pulses press_pulse.
REQ-016 Accepted-press latency: press_pulse and key_state rising SHALL occur in the cycle after DEBOUNCE_CYCLES consecutive sampled = 1 cycles, i.e. DEBOUNCE_CYCLES+2 cycles after a clean KEY fall.
REQ-017 HELD: the hold counter increments each cycle; on reaching LONG_CYCLES-1 the FSM goes to LONG_HELD and pulses long_pulse exactly once per press.
REQ-018 HELD or LONG_HELD with sampled = 0: the FSM SHALL go to DEB_REL with the debounce counter cleared, recording which held state it left.
REQ-019 DEB_REL: sampled = 1 returns the FSM to the recorded state (HELD or LONG_HELD) with no pulse.
- On return, the hold counter resumes from its frozen value; it is frozen while in DEB_REL.
REQ-020 DEB_REL release acceptance: when DEBOUNCE_CYCLES consecutive sampled = 0 cycles are counted, the FSM goes to IDLE and pulses release_pulse.
REQ-021 If the release is accepted in the same cycle a long count would complete, release takes priority and long_pulse SHALL NOT assert.
REQ-022 key_state SHALL be 1 in HELD, LONG_HELD and DEB_REL, and 0 in IDLE and DEB_PRESS.
- Its rising edge coincides with press_pulse; its falling edge coincides with release_pulse.
REQ-023 All outputs SHALL be registered.
- Each pulse is high for exactly one CLOCK_50 cycle.
- press_pulse, long_pulse and release_pulse never coincide on the same key.

Reset
REQ-024 RESET_N low SHALL immediately and asynchronously force:
- both synchronizer flops to released;
- all FSMs to IDLE and all counters to 0;
- key_state = 0, press_pulse = 0, release_pulse = 0, long_pulse = 0.
REQ-025 Reset asserted mid-press SHALL discard the press: no release_pulse is issued, and after RESET_N rises a still-held key SHALL be re-debounced from IDLE.
REQ-026 Reset deassertion is used as-is (board reset pre-synchronized upstream); the first active edge after deassertion SHALL behave as a normal cycle.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-027 Clean press: KEY[0] 1->0 and held for 10 cycles -> press_pulse[0] high for 1 cycle, 6 cycles after the fall; key_state[0]=1 from that cycle; other bits remain 0.
REQ-028 Bounce rejection: KEY[1] toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> no pulse of any kind and key_state[1]=0 throughout.
REQ-029 Long press: KEY[2] held low 30 cycles, then released cleanly.
- Expected: press_pulse, then exactly one long_pulse 16 cycles later, then release_pulse 6 cycles after KEY rises.
- key_state[2] falls with release_pulse.
REQ-030 Release glitch: while key 3 is HELD, KEY[3] goes high for 2 cycles then low -> no release_pulse, key_state[3] stays 1, and the hold count resumes (long_pulse still fires).
REQ-031 Reset mid-operation: RESET_N pulled low while key 0 is HELD and KEY[0] stays low -> all outputs 0 immediately.
- After RESET_N rises, press_pulse[0] recurs 6 cycles later.
- No release_pulse at any point.
REQ-032 Concurrent keys: all four KEY bits fall in the same cycle -> press_pulse = 4'b1111 in a single cycle, with identical timing per channel.

Source files
------------

// File: rtl/key_reader.sv
// Four-channel pushbutton reader: synchronizes active-low keys, debounces them and
// reports level, press, release and long-press strobes per key.
module key_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  output logic [3:0] key_state,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic [3:0] long_pulse
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W   = $clog2(LONG_CYCLES);
  // The entry cycle counts as the first stable sample, so the last compare is N-2.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG_HELD,
    DEB_REL
  } state_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] sampled;

  // Two-flop synchronizer; reset value is "released".
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign sampled = ~sync2;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    state_t              state, state_n;
    logic [DEB_W-1:0]    deb_cnt, deb_cnt_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic                from_long, from_long_n;
    logic                st_q, pr_q, rl_q, lg_q;
    logic                st_n, pr_n, rl_n, lg_n;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        state     <= IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        from_long <= 1'b0;
        st_q      <= 1'b0;
        pr_q      <= 1'b0;
        rl_q      <= 1'b0;
        lg_q      <= 1'b0;
      end else begin
        state     <= state_n;
        deb_cnt   <= deb_cnt_n;
        hold_cnt  <= hold_cnt_n;
        from_long <= from_long_n;
        st_q      <= st_n;
        pr_q      <= pr_n;
        rl_q      <= rl_n;
        lg_q      <= lg_n;
      end
    end

    always_comb begin
      state_n     = state;
      deb_cnt_n   = deb_cnt;
      hold_cnt_n  = hold_cnt;
      from_long_n = from_long;
      pr_n        = 1'b0;
      rl_n        = 1'b0;
      lg_n        = 1'b0;
      case (state)
        IDLE: begin
          if (sampled[g]) begin
            state_n   = DEB_PRESS;
            deb_cnt_n = '0;
          end
        end
        DEB_PRESS: begin
          if (!sampled[g]) begin
            state_n   = IDLE;
            deb_cnt_n = '0;
          end else if (deb_cnt == DEB_LAST) begin
            state_n    = HELD;
            hold_cnt_n = '0;
            pr_n       = 1'b1;
          end else begin
            deb_cnt_n = deb_cnt + DEB_W'(1);
          end
        end
        HELD: begin
          if (!sampled[g]) begin
            state_n     = DEB_REL;
            deb_cnt_n   = '0;
            from_long_n = 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_n = LONG_HELD;
            lg_n    = 1'b1;
          end else begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
          end
        end
        LONG_HELD: begin
          if (!sampled[g]) begin
            state_n     = DEB_REL;
            deb_cnt_n   = '0;
            from_long_n = 1'b1;
          end
        end
        DEB_REL: begin
          // Hold count stays frozen here so a rejected glitch resumes where it left off.
          if (sampled[g]) begin
            state_n = from_long ? LONG_HELD : HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state_n   = IDLE;
            deb_cnt_n = '0;
            rl_n      = 1'b1;
          end else begin
            deb_cnt_n = deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          state_n   = IDLE;
          deb_cnt_n = '0;
        end
      endcase
      st_n = (state_n == HELD) || (state_n == LONG_HELD) || (state_n == DEB_REL);
    end

    assign key_state[g]     = st_q;
    assign press_pulse[g]   = pr_q;
    assign release_pulse[g] = rl_q;
    assign long_pulse[g]    = lg_q;
  end

endmodule

// File: tb/tb_key_reader.sv
// Directed bench for key_reader with short debounce/long-press parameters.
module tb_key_reader;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 16;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [3:0] KEY;
  logic [3:0] key_state;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] long_pulse;

  key_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .KEY          (KEY),
    .key_state    (key_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] key;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [3:0] k, input logic [3:0] st, input logic [3:0] pr,
                     input logic [3:0] rl, input logic [3:0] lg);
    vec_t v;
    v.key = k;
    v.st  = st;
    v.pr  = pr;
    v.rl  = rl;
    v.lg  = lg;
    vecs.push_back(v);
  endtask

  task automatic run(input int n, input logic [3:0] k, input logic [3:0] st);
    for (int i = 0; i < n; i++) add(k, st, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] st,
                         input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg);
    chk({tag, ".key_state"}, idx, key_state, st);
    chk({tag, ".press"}, idx, press_pulse, pr);
    chk({tag, ".release"}, idx, release_pulse, rl);
    chk({tag, ".long"}, idx, long_pulse, lg);
  endtask

  initial begin
    // Clean press on key 0: press 6 cycles after fall, release 6 cycles after rise.
    run(5, 4'hE, 4'h0); add(4'hE, 4'h1, 4'h1, 4'h0, 4'h0); run(4, 4'hE, 4'h1);
    run(5, 4'hF, 4'h1); add(4'hF, 4'h0, 4'h0, 4'h1, 4'h0); run(2, 4'hF, 4'h0);
    // Key 1 bouncing with 2-cycle lows never gets accepted.
    for (int i = 0; i < 5; i++) begin
      run(2, 4'hD, 4'h0); run(2, 4'hF, 4'h0);
    end
    run(6, 4'hF, 4'h0);
    // Key 2 long press: long strobe 16 cycles after press.
    run(5, 4'hB, 4'h0); add(4'hB, 4'h4, 4'h4, 4'h0, 4'h0); run(15, 4'hB, 4'h4);
    add(4'hB, 4'h4, 4'h0, 4'h0, 4'h4); run(8, 4'hB, 4'h4);
    run(5, 4'hF, 4'h4); add(4'hF, 4'h0, 4'h0, 4'h4, 4'h0); run(2, 4'hF, 4'h0);
    // Key 3 release glitch: 3 frozen cycles push the long strobe to press+19.
    run(5, 4'h7, 4'h0); add(4'h7, 4'h8, 4'h8, 4'h0, 4'h0); run(2, 4'h7, 4'h8);
    run(2, 4'hF, 4'h8); run(14, 4'h7, 4'h8); add(4'h7, 4'h8, 4'h0, 4'h0, 4'h8);
    run(5, 4'h7, 4'h8); run(5, 4'hF, 4'h8); add(4'hF, 4'h0, 4'h0, 4'h8, 4'h0);
    run(2, 4'hF, 4'h0);
    // All four keys together.
    run(5, 4'h0, 4'h0); add(4'h0, 4'hF, 4'hF, 4'h0, 4'h0); run(4, 4'h0, 4'hF);
    run(5, 4'hF, 4'hF); add(4'hF, 4'h0, 4'h0, 4'hF, 4'h0); run(2, 4'hF, 4'h0);

    RESET_N = 1'b0;
    KEY     = 4'hF;
    #2;
    chk_all("reset_async", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    chk_all("reset", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    RESET_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      KEY = vecs[i].key;
      tick();
      chk_all("vec", i, vecs[i].st, vecs[i].pr, vecs[i].rl, vecs[i].lg);
    end

    // Reset while key 0 is held: outputs clear at once, press is re-debounced.
    KEY = 4'hE;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk_all("pre_rst", k, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);
    end
    #3;
    RESET_N = 1'b0;
    #1;
    chk_all("mid_rst", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    chk_all("mid_rst", 1, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    RESET_N = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all("post_rst", k, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);
    end
    KEY = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_all("post_rst_rel", k, (k < 6) ? 4'h1 : 4'h0, 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
